// File: rtl/div_req_sequencer.sv
// div_req_sequencer
//   Request/response front-end for a WIDTH-bit restoring divider. It accepts an
//   operand pair, converts signed operands to magnitudes and launches the divider.
//   It waits for a fresh div_rdy, applies sign correction, and holds the result
//   on a valid/ready response port. A zero divisor is answered locally without
//   launching the divider. A watchdog aborts a hung divider.
//
// Parameters
//   WIDTH        operand/result width (must match the divider)
//   TIMEOUT_CYC  number of wait cycles (WAIT_LO + WAIT_HI) allowed after div_run.
//                If div_rdy has not been seen high by the last of them, the
//                response is a timeout.
//
// Ports
//   clk, Rst                 clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready      request handshake (ready only while idle)
//   req_dvnd, req_dvsr       operands; req_signed selects two's-complement
//   rsp_valid/rsp_ready      response handshake (valid held until accepted)
//   rsp_q, rsp_r             quotient / remainder
//   rsp_dz, rsp_timeout      divide-by-zero / watchdog flags
//   div_run                  one-cycle divider launch pulse
//   div_dvnd, div_dvsr       operand magnitudes to the divider (held while busy)
//   div_rdy, div_q, div_r    divider result (level valid)
//   busy                     high whenever not idle
module div_req_sequencer #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned TIMEOUT_CYC = 80
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_dvnd,
  input  logic [WIDTH-1:0] req_dvsr,
  input  logic             req_signed,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_q,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_dz,
  output logic             rsp_timeout,
  output logic             div_run,
  output logic [WIDTH-1:0] div_dvnd,
  output logic [WIDTH-1:0] div_dvsr,
  input  logic             div_rdy,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  output logic             busy
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_LO,
    WAIT_HI,
    FIX,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    wd_cnt;
  logic             wd_last;
  logic             sign_q, sign_r;
  logic [WIDTH-1:0] cap_q, cap_r;
  logic             dvnd_neg, dvsr_neg, dvsr_zero;
  logic             accept, capture, wd_expired, rsp_done;

  assign dvnd_neg  = req_signed & req_dvnd[WIDTH-1];
  assign dvsr_neg  = req_signed & req_dvsr[WIDTH-1];
  assign dvsr_zero = (req_dvsr == '0);
  // Counter starts at 0 on the first wait cycle, so this marks the last allowed one.
  assign wd_last   = (wd_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    div_run    = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    capture    = 1'b0;
    wd_expired = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = dvsr_zero ? RESP : LAUNCH;
        end
      end
      LAUNCH: begin
        div_run   = 1'b1;
        state_nxt = WAIT_LO;
      end
      // A result still high from the previous operation must drop first.
      WAIT_LO: begin
        if (wd_last) begin
          wd_expired = 1'b1;
          state_nxt  = RESP;
        end else if (!div_rdy) begin
          state_nxt = WAIT_HI;
        end
      end
      // A result arriving on the last allowed cycle wins over the watchdog.
      WAIT_HI: begin
        if (div_rdy) begin
          capture   = 1'b1;
          state_nxt = FIX;
        end else if (wd_last) begin
          wd_expired = 1'b1;
          state_nxt  = RESP;
        end
      end
      FIX: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      div_dvnd    <= '0;
      div_dvsr    <= '0;
      cap_q       <= '0;
      cap_r       <= '0;
      rsp_q       <= '0;
      rsp_r       <= '0;
      rsp_dz      <= 1'b0;
      rsp_timeout <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      if (accept) begin
        sign_q   <= req_signed & (req_dvnd[WIDTH-1] ^ req_dvsr[WIDTH-1]);
        sign_r   <= dvnd_neg;
        div_dvnd <= dvnd_neg ? -req_dvnd : req_dvnd;
        div_dvsr <= dvsr_neg ? -req_dvsr : req_dvsr;
        if (dvsr_zero) begin
          rsp_q  <= '1;
          rsp_r  <= req_dvnd;
          rsp_dz <= 1'b1;
        end
      end

      if (state == LAUNCH) begin
        wd_cnt <= '0;
      end else if (state == WAIT_LO || state == WAIT_HI) begin
        wd_cnt <= wd_cnt + 1'b1;
      end

      if (capture) begin
        cap_q <= div_q;
        cap_r <= div_r;
      end

      // Negation wraps mod 2^WIDTH, so the -2^(W-1) / -1 overflow yields 2^(W-1).
      if (state == FIX) begin
        rsp_q <= sign_q ? -cap_q : cap_q;
        rsp_r <= sign_r ? -cap_r : cap_r;
      end

      if (wd_expired) begin
        rsp_q       <= '0;
        rsp_r       <= '0;
        rsp_timeout <= 1'b1;
      end

      if (rsp_done) begin
        rsp_dz      <= 1'b0;
        rsp_timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_req_sequencer.sv
// Testbench for div_req_sequencer: a behavioural divider drives div_rdy/div_q/div_r
// with configurable stale-high, low and hang phases; a transaction-level model
// predicts response values and response cycle from the request and divider plan.
module tb_div_req_sequencer;

  localparam int T = 80;

  logic        clk = 1'b0;
  logic        Rst;
  logic        req_valid, req_ready, req_signed;
  logic [31:0] req_dvnd, req_dvsr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_q, rsp_r;
  logic        rsp_dz, rsp_timeout;
  logic        div_run, div_rdy, busy;
  logic [31:0] div_dvnd, div_dvsr, div_q, div_r;

  always #5 clk = ~clk;

  div_req_sequencer #(.WIDTH(32), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .Rst(Rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dvnd(req_dvnd), .req_dvsr(req_dvsr), .req_signed(req_signed),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dz(rsp_dz), .rsp_timeout(rsp_timeout),
    .div_run(div_run), .div_dvnd(div_dvnd), .div_dvsr(div_dvsr),
    .div_rdy(div_rdy), .div_q(div_q), .div_r(div_r),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%h required=0x%h", nm, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider plan for the request currently offered on the request port.
  int p_stale = 0, p_low = 1, p_hang = 0;
  typedef struct { int stale; int low; int hang; } plan_t;
  plan_t plan_q[$];

  // Behavioural divider: after a run it keeps rdy high (stale) for d_stale cycles,
  // drops it for d_low cycles, then presents the true result. hang 1/2 = stuck low/high.
  int          dcnt = 1000000;
  int          d_stale = 0, d_low = 0, d_hang = 0;
  logic [31:0] d_a = '0, d_b = '0;

  always @(posedge clk) begin
    if (div_run) begin
      dcnt <= 1;
      d_a  <= div_dvnd;
      d_b  <= div_dvsr;
      if (plan_q.size() > 0) begin
        d_stale <= plan_q[0].stale;
        d_low   <= plan_q[0].low;
        d_hang  <= plan_q[0].hang;
        void'(plan_q.pop_front());
      end
    end else if (dcnt < 1000000) begin
      dcnt <= dcnt + 1;
    end
  end

  always_comb begin
    div_rdy = 1'b0;
    div_q   = 32'hDEAD_BEEF;
    div_r   = 32'hBAAD_F00D;
    if (d_hang == 1) div_rdy = 1'b0;
    else if (d_hang == 2) div_rdy = 1'b1;
    else if (dcnt <= d_stale) div_rdy = 1'b1;
    else if (dcnt <= d_stale + d_low) div_rdy = 1'b0;
    else begin
      div_rdy = 1'b1;
      if (d_b != 0) begin
        div_q = d_a / d_b;
        div_r = d_a % d_b;
      end
    end
  end

  function automatic void model_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 0) begin q = '1; r = a; end
    else if (!s) begin q = a / b; r = a % b; end
    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = 32'h8000_0000; r = '0; end
    else begin q = sa / sb; r = sa % sb; end
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
    return (s && x[31]) ? -x : x;
  endfunction

  // Transaction model
  bit          m_busy = 0, m_has_run = 0, m_dz = 0, m_to = 0;
  int          m_hs = 0, m_vcyc = 0;
  logic [31:0] m_q = '0, m_r = '0, m_ma = '0, m_mb = '0;
  int          run_count = 0;
  logic [31:0] last_run_dvnd = '0;

  always @(negedge clk) begin
    bit exp_v, exp_run;
    int run_c;
    plan_t pl;
    if (!Rst) begin
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_div_run", div_run, 0);
      chk("rst_rsp_dz", rsp_dz, 0);
      chk("rst_rsp_timeout", rsp_timeout, 0);
      chk("rst_rsp_q", rsp_q, 0);
      chk("rst_rsp_r", rsp_r, 0);
      chk("rst_div_dvnd", div_dvnd, 0);
      chk("rst_div_dvsr", div_dvsr, 0);
      m_busy = 0;
      plan_q.delete();
    end else begin
      chk("busy", busy, m_busy);
      chk("req_ready", req_ready, !m_busy);
      exp_run = m_busy && m_has_run && (cyc == m_hs + 1);
      chk("div_run", div_run, exp_run);
      if (div_run) begin
        run_count++;
        last_run_dvnd = div_dvnd;
      end
      exp_v = m_busy && (cyc >= m_vcyc);
      chk("rsp_valid", rsp_valid, exp_v);
      if (exp_v) begin
        chk("rsp_q", rsp_q, m_q);
        chk("rsp_r", rsp_r, m_r);
        chk("rsp_dz", rsp_dz, m_dz);
        chk("rsp_timeout", rsp_timeout, m_to);
      end
      if (m_busy && m_has_run && cyc > m_hs) begin
        chk("div_dvnd", div_dvnd, m_ma);
        chk("div_dvsr", div_dvsr, m_mb);
      end
      if (m_busy) begin
        if (exp_v && rsp_ready) m_busy = 0;
      end else if (req_valid) begin
        m_busy    = 1;
        m_hs      = cyc;
        m_has_run = (req_dvsr != 0);
        m_ma      = mag(req_dvnd, req_signed);
        m_mb      = mag(req_dvsr, req_signed);
        model_div(req_dvnd, req_dvsr, req_signed, m_q, m_r);
        m_dz = (req_dvsr == 0);
        m_to = 0;
        if (!m_has_run) begin
          m_vcyc = cyc + 1;
        end else begin
          run_c = cyc + 1;
          pl.stale = p_stale; pl.low = p_low; pl.hang = p_hang;
          plan_q.push_back(pl);
          if (p_hang != 0 || p_stale + p_low + 1 > T) begin
            m_vcyc = run_c + T + 1;
            m_to   = 1;
            m_q    = '0;
            m_r    = '0;
          end else begin
            m_vcyc = run_c + p_stale + p_low + 1 + 2;
          end
        end
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int st, input int lo, input int hg, input int hold,
                        output logic [31:0] q, output logic [31:0] r,
                        output logic dz, output logic to, output int runs, output int lat);
    int n, snap, hs;
    snap = run_count;
    @(posedge clk); #1;
    p_stale = st; p_low = lo; p_hang = hg;
    req_dvnd = a; req_dvsr = b; req_signed = s; req_valid = 1'b1; rsp_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    chk("req_handshake_wait", req_ready, 1);
    hs = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
    chk("rsp_wait", rsp_valid, 1);
    lat = cyc - hs;
    q = rsp_q; r = rsp_r; dz = rsp_dz; to = rsp_timeout;
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk("hold_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    runs = run_count - snap;
  endtask

  logic [31:0] q, r;
  logic        dz, to;
  int          runs, lat;

  initial begin
    Rst = 1'b0; req_valid = 1'b0; req_signed = 1'b0; rsp_ready = 1'b0;
    req_dvnd = '0; req_dvsr = '0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 Rst = 1'b1;

    do_req(32'd100, 32'd7, 1'b0, 0, 3, 0, 10, q, r, dz, to, runs, lat);
    chk("u100_7_q", q, 14); chk("u100_7_r", r, 2); chk("u100_7_dz", dz, 0);
    chk("u100_7_runs", runs, 1); chk("u100_7_lat", lat, 7);

    do_req(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 2, 0, 0, q, r, dz, to, runs, lat);
    chk("sm7_2_q", q, 32'hFFFF_FFFD); chk("sm7_2_r", r, 32'hFFFF_FFFF);
    chk("sm7_2_dvnd", last_run_dvnd, 7);

    do_req(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 2, 0, 0, q, r, dz, to, runs, lat);
    chk("s7_m2_q", q, 32'hFFFF_FFFD); chk("s7_m2_r", r, 1);

    do_req(32'h1234, 32'd0, 1'b0, 0, 2, 0, 3, q, r, dz, to, runs, lat);
    chk("dz_q", q, 32'hFFFF_FFFF); chk("dz_r", r, 32'h1234); chk("dz_flag", dz, 1);
    chk("dz_runs", runs, 0); chk("dz_lat", lat, 1);

    do_req(32'd1000, 32'd10, 1'b0, 6, 2, 0, 0, q, r, dz, to, runs, lat);
    chk("stale_q", q, 100); chk("stale_r", r, 0); chk("stale_lat", lat, 12);

    do_req(32'd55, 32'd5, 1'b0, 0, 1, 1, 0, q, r, dz, to, runs, lat);
    chk("hang_lo_to", to, 1); chk("hang_lo_q", q, 0); chk("hang_lo_r", r, 0);
    chk("hang_lo_lat", lat, 82);

    do_req(32'd99, 32'd9, 1'b0, 0, 79, 0, 0, q, r, dz, to, runs, lat);
    chk("edge_in_to", to, 0); chk("edge_in_q", q, 11); chk("edge_in_lat", lat, 83);

    do_req(32'd99, 32'd9, 1'b0, 0, 80, 0, 0, q, r, dz, to, runs, lat);
    chk("edge_out_to", to, 1); chk("edge_out_lat", lat, 82);

    do_req(32'd99, 32'd9, 1'b0, 0, 1, 2, 0, q, r, dz, to, runs, lat);
    chk("hang_hi_to", to, 1); chk("hang_hi_q", q, 0);

    do_req(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 3, 0, 0, q, r, dz, to, runs, lat);
    chk("ovf_q", q, 32'h8000_0000); chk("ovf_r", r, 0); chk("ovf_to", to, 0);

    // Reset while waiting for div_rdy high.
    @(posedge clk); #1;
    p_stale = 0; p_low = 30; p_hang = 0;
    req_dvnd = 32'd500; req_dvsr = 32'd5; req_signed = 1'b0; req_valid = 1'b1;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 200) begin @(negedge clk); n++; end
    end
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    @(posedge clk); #1 Rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dvnd", div_dvnd, 0);
    repeat (2) @(posedge clk);
    #1 Rst = 1'b1;

    do_req(32'd100, 32'd7, 1'b0, 0, 3, 0, 0, q, r, dz, to, runs, lat);
    chk("post_rst_q", q, 14); chk("post_rst_r", r, 2);

    // Randomized stream: requests may be offered while busy, response back-pressure random.
    begin
      int  issued, sel;
      bit  pend, got_hs;
      issued = 0; pend = 0; got_hs = 0;
      for (int k = 0; k < 20000; k++) begin
        if (issued == 120 && !pend && !m_busy) break;
        @(posedge clk); #1;
        if (got_hs) begin
          req_valid = 1'b0;
          pend = 0;
          got_hs = 0;
        end
        if (!pend && issued < 120 && $urandom_range(0, 3) != 0) begin
          sel = $urandom_range(0, 9);
          req_dvnd   = $urandom;
          req_dvsr   = $urandom;
          req_signed = $urandom_range(0, 1);
          if (sel == 0) req_dvsr = '0;
          else if (sel == 1) begin req_dvnd = 32'h8000_0000; req_dvsr = 32'hFFFF_FFFF; end
          else if (sel == 2) req_dvsr = $urandom_range(1, 16);
          else if (sel == 3) req_dvnd = $urandom_range(0, 100);
          else if (sel == 4) req_dvsr = -$urandom_range(1, 16);
          p_stale = $urandom_range(0, 3);
          p_low   = $urandom_range(1, 40);
          p_hang  = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 2) : 0;
          req_valid = 1'b1;
          pend = 1;
          issued++;
        end
        rsp_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (req_valid && req_ready) got_hs = 1;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("drain_busy", busy, 0);
      chk("drain_issued", issued, 120);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
